// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// State encodings are kept as 3-bit constants for compatibility with legacy users.
package m_imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_CNT_HI = 3'd0;
    localparam state_t S_CNT_LO = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_CSUM   = 3'd3;
    localparam state_t S_DONE   = 3'd4;
    localparam state_t S_ERR    = 3'd5;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

    // The loader takes bytes only while a frame is still in progress.
    function automatic logic state_accepts(input state_t s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/m_imem_loader_if.sv
// Host byte-stream link into the loader (valid/ready, one byte per transfer).
interface m_imem_loader_if;

    logic [7:0] w_din;
    logic       w_valid;
    logic       r_ready;

    modport master (output w_din, output w_valid, input r_ready);
    modport slave  (input w_din, input w_valid, output r_ready);

endinterface

// File: rtl/m_imem_loader_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words; the completed word and its
// strobe are presented combinationally in the cycle the last byte is accepted.
module m_byte_packer
    import m_imem_loader_pkg::*;
(
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_en,
    input  logic [7:0]  w_byte,
    output logic [31:0] r_word,
    output logic        r_word_done
);

    logic [23:0] shift;
    logic [1:0]  byte_cnt;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (w_en) begin
            shift    <= {shift[15:0], w_byte};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Exposing the word before it is registered lets the top's write stage
    // strobe memory in the very next cycle.
    assign r_word      = {shift, w_byte};
    assign r_word_done = w_en && (byte_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/m_imem_loader.sv
// Boot-time program loader: receives a counted, XOR-checksummed byte frame,
// writes the packed words to imem and releases the processor once verified.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned BASE   = 0
) (
    input  logic              w_clk,
    input  logic              w_rst,
    m_imem_loader_if.slave    link,
    output logic              r_mem_we,
    output logic [ADDR_W-1:0] r_mem_addr,
    output logic [31:0]       r_mem_din,
    output logic              r_proc_rst,
    output logic              r_done,
    output logic              r_err
);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        cnt_hi;
    logic [15:0]       n_words;
    logic [15:0]       word_idx;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        csum;
    logic              r_ready;
    logic              xfer;
    logic [15:0]       n_rx;
    logic [31:0]       packed_word;
    logic              word_done;

    assign link.r_ready = r_ready;
    assign xfer         = link.w_valid && r_ready;
    assign n_rx         = {cnt_hi, link.w_din};

    m_byte_packer u_packer (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_en        (xfer && (state == S_DATA)),
        .w_byte      (link.w_din),
        .r_word      (packed_word),
        .r_word_done (word_done)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_CNT_HI: if (xfer) state_nx = S_CNT_LO;
            S_CNT_LO: begin
                if (xfer) begin
                    if (n_rx == 16'd0)
                        state_nx = S_CSUM;
                    else if ({16'd0, n_rx} > 32'(DEPTH))
                        state_nx = S_ERR;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA:   if (word_done && (word_idx == n_words - 16'd1)) state_nx = S_CSUM;
            S_CSUM:   if (xfer) state_nx = (link.w_din == csum) ? S_DONE : S_ERR;
            S_DONE:   state_nx = S_DONE;
            S_ERR:    state_nx = S_ERR;
            default:  state_nx = S_ERR;
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state itself; this also drops ready before a stray byte.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state      <= S_CNT_HI;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_proc_rst <= 1'b1;
            cnt_hi     <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            addr_cnt   <= ADDR_W'(BASE);
            csum       <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= ADDR_W'(BASE);
            r_mem_din  <= '0;
        end else begin
            state      <= state_nx;
            r_ready    <= state_accepts(state_nx);
            r_done     <= (state_nx == S_DONE);
            r_err      <= (state_nx == S_ERR);
            r_proc_rst <= (state_nx != S_DONE);
            r_mem_we   <= word_done;

            if (xfer && (state != S_CSUM))
                csum <= csum ^ link.w_din;
            if (xfer && (state == S_CNT_HI))
                cnt_hi <= link.w_din;
            if (xfer && (state == S_CNT_LO))
                n_words <= n_rx;

            if (word_done) begin
                r_mem_addr <= addr_cnt;
                r_mem_din  <= packed_word;
                addr_cnt   <= addr_cnt + 1'b1;
                word_idx   <= word_idx + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed self-checking bench for the imem loader.
module tb_m_imem_loader;

    logic        w_clk;
    logic        w_rst;
    logic        r_mem_we;
    logic [11:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic        r_proc_rst;
    logic        r_done;
    logic        r_err;

    int checks;
    int errors;
    int wr_count;

    m_imem_loader_if link ();

    m_imem_loader #(
        .ADDR_W (12),
        .DEPTH  (4096),
        .BASE   (0)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .link       (link.slave),
        .r_mem_we   (r_mem_we),
        .r_mem_addr (r_mem_addr),
        .r_mem_din  (r_mem_din),
        .r_proc_rst (r_proc_rst),
        .r_done     (r_done),
        .r_err      (r_err)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) if (r_mem_we === 1'b1) wr_count <= wr_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        link.w_valid = 1'b0;
        link.w_din = 8'h00;
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b0;
        @(negedge w_clk);
    endtask

    // Offers one byte, waiting (bounded) for ready, then checks the write strobe
    // in the cycle following the accepting edge.
    task automatic send(input logic [7:0] b, input int gap, input logic exp_we,
                        input logic [11:0] exp_addr, input logic [31:0] exp_data);
        int n;
        repeat (gap) @(negedge w_clk);
        n = 0;
        while (link.r_ready !== 1'b1 && n < 20) begin
            @(negedge w_clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, link.r_ready}, 32'd1);
        link.w_din = b;
        link.w_valid = 1'b1;
        @(negedge w_clk);
        link.w_valid = 1'b0;
        chk("we_timing", {31'd0, r_mem_we}, {31'd0, exp_we});
        if (exp_we) begin
            chk("wr_addr", {20'd0, r_mem_addr}, {20'd0, exp_addr});
            chk("wr_data", r_mem_din, exp_data);
        end
    endtask

    logic [7:0]  frame [11];
    logic [31:0] words [2];

    task automatic load2(input logic [7:0] csum_byte, input logic gappy);
        logic w;
        int   k;
        frame[10] = csum_byte;
        for (int i = 0; i < 11; i++) begin
            k = (i - 2) / 4;
            w = (i >= 2) && (i < 10) && (((i - 2) % 4) == 3);
            send(frame[i], gappy ? int'($urandom_range(0, 1)) : 0, w,
                 12'(k), w ? words[k[0]] : 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_count = 0;
        frame = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        words = '{32'h11223344, 32'h55667788};
        w_rst = 1'b1;
        link.w_valid = 1'b0;
        link.w_din = 8'h00;

        // Reset state
        @(negedge w_clk);
        @(negedge w_clk);
        chk("rst_ready", {31'd0, link.r_ready}, 32'd0);
        chk("rst_we", {31'd0, r_mem_we}, 32'd0);
        chk("rst_addr", {20'd0, r_mem_addr}, 32'd0);
        chk("rst_din", r_mem_din, 32'd0);
        chk("rst_proc", {31'd0, r_proc_rst}, 32'd1);
        chk("rst_flags", {30'd0, r_done, r_err}, 32'd0);
        w_rst = 1'b0;
        @(negedge w_clk);
        chk("ready_after_rst", {31'd0, link.r_ready}, 32'd1);

        // Good 2-word load
        load2(8'h8A, 1'b0);
        chk("good_done", {31'd0, r_done}, 32'd1);
        chk("good_err", {31'd0, r_err}, 32'd0);
        chk("good_proc", {31'd0, r_proc_rst}, 32'd0);
        chk("good_ready", {31'd0, link.r_ready}, 32'd0);
        @(negedge w_clk);
        chk("good_wrcount", wr_count, 32'd2);

        // Bytes after DONE are ignored
        link.w_din = 8'hAA;
        link.w_valid = 1'b1;
        repeat (6) @(negedge w_clk);
        link.w_valid = 1'b0;
        @(negedge w_clk);
        chk("post_done_wrcount", wr_count, 32'd2);
        chk("post_done_flags", {29'd0, r_done, r_err, r_proc_rst}, 32'b100);
        chk("post_done_addr", {20'd0, r_mem_addr}, 32'd1);

        // Bad checksum
        do_reset();
        wr_count = 0;
        load2(8'h8B, 1'b0);
        @(negedge w_clk);
        chk("bad_wrcount", wr_count, 32'd2);
        chk("bad_err", {31'd0, r_err}, 32'd1);
        chk("bad_done", {31'd0, r_done}, 32'd0);
        chk("bad_proc", {31'd0, r_proc_rst}, 32'd1);
        chk("bad_ready", {31'd0, link.r_ready}, 32'd0);

        // Empty image
        do_reset();
        wr_count = 0;
        send(8'h00, 0, 1'b0, 12'd0, 32'd0);
        send(8'h00, 0, 1'b0, 12'd0, 32'd0);
        send(8'h00, 0, 1'b0, 12'd0, 32'd0);
        @(negedge w_clk);
        chk("n0_wrcount", wr_count, 32'd0);
        chk("n0_done", {31'd0, r_done}, 32'd1);
        chk("n0_proc", {31'd0, r_proc_rst}, 32'd0);

        // Count above DEPTH
        do_reset();
        send(8'h10, 0, 1'b0, 12'd0, 32'd0);
        send(8'h01, 0, 1'b0, 12'd0, 32'd0);
        chk("big_err", {31'd0, r_err}, 32'd1);
        chk("big_ready", {31'd0, link.r_ready}, 32'd0);

        // Count equal to DEPTH is legal
        do_reset();
        send(8'h10, 0, 1'b0, 12'd0, 32'd0);
        send(8'h00, 0, 1'b0, 12'd0, 32'd0);
        chk("depth_err", {31'd0, r_err}, 32'd0);
        chk("depth_ready", {31'd0, link.r_ready}, 32'd1);

        // Gappy valid
        do_reset();
        wr_count = 0;
        load2(8'h8A, 1'b1);
        @(negedge w_clk);
        chk("gap_wrcount", wr_count, 32'd2);
        chk("gap_done", {31'd0, r_done}, 32'd1);

        // Reset mid-load, then a full frame
        do_reset();
        for (int i = 0; i < 8; i++)
            send(frame[i], 0, i == 5, 12'd0, words[0]);
        do_reset();
        chk("midrst_ready", {31'd0, link.r_ready}, 32'd1);
        chk("midrst_flags", {29'd0, r_done, r_err, r_proc_rst}, 32'b001);
        wr_count = 0;
        load2(8'h8A, 1'b0);
        @(negedge w_clk);
        chk("midrst_wrcount", wr_count, 32'd2);
        chk("midrst_done", {31'd0, r_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
